// File: rtl/hazard_ctrl_pkg.sv
// core: shared hazard-controller state encoding and register constants
package core;
    typedef enum logic [1:0] {HZ_RUN, HZ_MD_BUSY, HZ_FLUSH} hz_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/hold/flush scheduling for the IF/ID/EX front end
module hazard_ctrl
    import core::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MD_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             id_is_md_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             redirect_i,
    input  logic             md_done_i,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic             if_flush_o,
    output logic             id_flush_o,
    output logic             ex_hold_o,
    output logic             md_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int WD_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);
    localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);

    hz_state_t       state;
    logic [2:0]      fcnt;
    logic [WD_W-1:0] wd;
    logic            luse, accept, md_hold, flush, stall, md_enter;

    assign luse = ex_valid_i & ex_is_load_i & (ex_rd_i != REG_ZERO) & id_valid_i &
                  ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    // a mul/div in flight is the oldest instruction, so redirects seen then are dropped
    assign accept   = redirect_i & (state != HZ_MD_BUSY);
    assign md_hold  = (state == HZ_MD_BUSY) & !md_done_i;
    assign flush    = accept | (state == HZ_FLUSH);
    assign stall    = !flush & (md_hold | ((state == HZ_RUN) & luse));
    assign md_enter = (state == HZ_RUN) & !redirect_i & !luse & id_valid_i & id_is_md_i;

    assign if_stall_o = stall;
    assign id_stall_o = stall;
    assign if_flush_o = flush;
    assign id_flush_o = flush;
    assign ex_hold_o  = md_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= HZ_RUN;
            fcnt         <= '0;
            wd           <= '0;
            md_timeout_o <= 1'b0;
        end else if (accept) begin
            fcnt  <= FC_LOAD;
            state <= (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
        end else if (state == HZ_FLUSH) begin
            fcnt <= fcnt - 3'd1;
            if (fcnt <= 3'd1) state <= HZ_RUN;
        end else if (md_enter) begin
            state <= HZ_MD_BUSY;
            wd    <= '0;
        end else if (state == HZ_MD_BUSY) begin
            if (md_done_i) state <= HZ_RUN;
            else if (wd == WD_LAST) begin
                md_timeout_o <= 1'b1;
                state        <= HZ_RUN;
            end else wd <= wd + 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .inc(stall), .clr(1'b0), .cnt(stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .inc(accept), .clr(1'b0), .cnt(flush_cnt_o)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with FLUSH_CYCLES=3, MD_TIMEOUT=64, CNT_W=4
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_use_rs1, id_use_rs2, id_is_md;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_is_load, redirect, md_done;
    logic       if_stall, id_stall, if_flush, id_flush, ex_hold, md_timeout;
    logic [3:0] stall_cnt, flush_cnt;
    logic [4:0] ctl;
    int         total = 0;
    int         bad = 0;

    hazard_ctrl #(.FLUSH_CYCLES(3), .MD_TIMEOUT(64), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_is_md_i(id_is_md),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd),
        .redirect_i(redirect), .md_done_i(md_done),
        .if_stall_o(if_stall), .id_stall_o(id_stall), .if_flush_o(if_flush),
        .id_flush_o(id_flush), .ex_hold_o(ex_hold), .md_timeout_o(md_timeout),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;
    assign ctl = {if_stall, id_stall, if_flush, id_flush, ex_hold};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {id_valid, id_use_rs1, id_use_rs2, id_is_md, ex_valid, ex_is_load, redirect, md_done} = '0;
        id_rs1 = '0;
        id_rs2 = '0;
        ex_rd  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_luse(input logic [4:0] rd);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
        id_valid = 1'b1; id_rs2 = rd; id_use_rs2 = 1'b1;
    endtask

    initial begin
        idle();
        #1 rst = 1'b0;
        #1;
        chk("reset_ctl", ctl, 5'b00000);
        chk("reset_cnt", {stall_cnt, flush_cnt}, 8'h00);
        chk("reset_tmo", md_timeout, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        set_luse(5'd5);
        #3 chk("luse_stall", ctl, 5'b11000);
        step();
        idle();
        #3 chk("luse_one_cycle", ctl, 5'b00000);
        chk("luse_cnt", stall_cnt, 4'd1);
        set_luse(5'd0);
        #3 chk("rd0_no_stall", ctl, 5'b00000);
        step();
        idle();
        set_luse(5'd7);
        id_valid = 1'b0;
        #3 chk("idvalid0_no_stall", ctl, 5'b00000);
        step();
        idle();
        redirect = 1'b1;
        #3 chk("redir_c0", ctl, 5'b00110);
        step();
        redirect = 1'b0;
        #3 chk("redir_c1", ctl, 5'b00110);
        chk("redir_cnt1", flush_cnt, 4'd1);
        step();
        redirect = 1'b1;
        #3 chk("redir_c2", ctl, 5'b00110);
        step();
        redirect = 1'b0;
        #3 chk("redir_c3", ctl, 5'b00110);
        chk("redir_cnt2", flush_cnt, 4'd2);
        step();
        #3 chk("redir_c4", ctl, 5'b00110);
        step();
        #3 chk("redir_c5_done", ctl, 5'b00000);
        redirect = 1'b1;
        set_luse(5'd9);
        #1 chk("redir_luse", ctl, 5'b00110);
        step();
        idle();
        set_luse(5'd9);
        id_is_md = 1'b1;
        #3 chk("flush_ignores_luse", ctl, 5'b00110);
        step();
        idle();
        step();
        #3 chk("after_redir_luse", ctl, 5'b00000);
        chk("redir_luse_cnts", {stall_cnt, flush_cnt}, 8'h13);
        rst = 1'b0;
        #1 rst = 1'b1;
        chk("rst2_cnt", {stall_cnt, flush_cnt}, 8'h00);
        id_valid = 1'b1;
        id_is_md = 1'b1;
        #2 chk("md_c0", ctl, 5'b00000);
        step();
        idle();
        for (int i = 1; i <= 9; i++) begin
            #3 chk("md_busy", ctl, 5'b11001);
            step();
        end
        md_done = 1'b1;
        #3 chk("md_done_c10", ctl, 5'b00000);
        step();
        md_done = 1'b0;
        #3 chk("md_after", ctl, 5'b00000);
        chk("md_stall_cnt", stall_cnt, 4'd9);
        id_valid = 1'b1;
        id_is_md = 1'b1;
        #1 chk("wd_c0", ctl, 5'b00000);
        step();
        idle();
        for (int i = 1; i <= 64; i++) begin
            #3 chk("wd_busy", ctl, 5'b11001);
            if (i == 64) chk("wd_not_yet", md_timeout, 1'b0);
            step();
        end
        #3 chk("wd_fired", md_timeout, 1'b1);
        chk("wd_run", ctl, 5'b00000);
        chk("wd_stall_sat", stall_cnt, 4'd15);
        step();
        step();
        #3 chk("wd_sticky", md_timeout, 1'b1);
        id_is_md = 1'b1;
        #1 chk("md_idvalid0_c0", ctl, 5'b00000);
        step();
        #3 chk("md_idvalid0_c1", ctl, 5'b00000);
        idle();
        id_valid = 1'b1;
        id_is_md = 1'b1;
        step();
        idle();
        step();
        #1 chk("md_before_rst", ctl, 5'b11001);
        rst = 1'b0;
        #1 chk("async_rst_ctl", ctl, 5'b00000);
        chk("async_rst_cnt", {stall_cnt, flush_cnt}, 8'h00);
        chk("async_rst_tmo", md_timeout, 1'b0);
        #1 rst = 1'b1;
        set_luse(5'd3);
        #1 chk("sat_luse", ctl, 5'b11000);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("sat_cnt14", stall_cnt, 4'd14);
        end
        chk("sat_cnt20", stall_cnt, 4'd15);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
